// File: rtl/pipe_stage_reg_pkg.sv
// Shared types and per-stage constants for the segmented RV32 inter-stage registers.
// Each pipe_stage_reg instance takes its CTRL_W and BUBBLE_CTRL values from here.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } stage_state_e;

    localparam int FE_DE_CTRL_W = 4;
    localparam int DE_EX_CTRL_W = 16;
    localparam int EX_ME_CTRL_W = 8;
    localparam int ME_WB_CTRL_W = 4;

    // Bubbles must never assert RuWr or DMWr; all-zero encodes both as off.
    localparam logic [FE_DE_CTRL_W-1:0] FE_DE_BUBBLE = '0;
    localparam logic [DE_EX_CTRL_W-1:0] DE_EX_BUBBLE = '0;
    localparam logic [EX_ME_CTRL_W-1:0] EX_ME_BUBBLE = '0;
    localparam logic [ME_WB_CTRL_W-1:0] ME_WB_BUBBLE = '0;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating event counter: counts up once per cycle with inc high, sticks at all-ones.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage register with valid/ready handshake, flush, optional
// 2-entry skid buffer and saturating stall/flush counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W      = 32,
    parameter int                CTRL_W      = 16,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0,
    parameter int                SKID        = 1,
    parameter int                CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output stage_state_e      state_dbg
);

    // Handshake: a bundle moves on a cycle where valid && ready are both high at the
    // rising edge; a sender holds valid and payload stable until that happens, and
    // the receiver's ready may be asserted independently of valid.

    stage_state_e      state;
    stage_state_e      stateNext;
    logic [DATA_W-1:0] mainData;
    logic [DATA_W-1:0] skidData;
    logic [CTRL_W-1:0] mainCtrl;
    logic [CTRL_W-1:0] skidCtrl;
    logic              inReadyQ;
    logic              inFire;
    logic              outFire;
    logic              loadMain;
    logic              mainFromSkid;
    logic              loadSkid;
    logic              stallInc;
    logic              flushInc;

    assign out_valid = (state != EMPTY);
    assign out_data  = mainData;
    assign out_ctrl  = out_valid ? mainCtrl : BUBBLE_CTRL;
    assign state_dbg = state;

    // Without a skid slot, inReadyQ only masks ready until the first edge after reset.
    assign in_ready = (SKID != 0) ? inReadyQ : (inReadyQ && (!out_valid || out_ready));

    assign inFire  = in_valid && in_ready;
    assign outFire = out_valid && out_ready;

    always_comb begin
        stateNext    = state;
        loadMain     = 1'b0;
        mainFromSkid = 1'b0;
        loadSkid     = 1'b0;
        case (state)
            EMPTY: begin
                if (inFire) begin
                    stateNext = ONE;
                    loadMain  = 1'b1;
                end
            end
            ONE: begin
                if (inFire && outFire) begin
                    loadMain = 1'b1;
                end else if (inFire) begin
                    stateNext = FULL;
                    loadSkid  = 1'b1;
                end else if (outFire) begin
                    stateNext = EMPTY;
                end
            end
            FULL: begin
                if (outFire) begin
                    stateNext    = ONE;
                    loadMain     = 1'b1;
                    mainFromSkid = 1'b1;
                end
            end
            default: stateNext = EMPTY;
        endcase
        // Flush wins over everything, including a bundle accepted this same cycle.
        if (flush) begin
            stateNext    = EMPTY;
            loadMain     = 1'b0;
            mainFromSkid = 1'b0;
            loadSkid     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            inReadyQ <= 1'b0;
            mainData <= '0;
            mainCtrl <= BUBBLE_CTRL;
            skidData <= '0;
            skidCtrl <= BUBBLE_CTRL;
        end else begin
            state    <= stateNext;
            inReadyQ <= (SKID != 0) ? (stateNext != FULL) : 1'b1;
            if (loadMain) begin
                mainData <= mainFromSkid ? skidData : in_data;
                mainCtrl <= mainFromSkid ? skidCtrl : in_ctrl;
            end
            if (loadSkid) begin
                skidData <= in_data;
                skidCtrl <= in_ctrl;
            end
        end
    end

    assign stallInc = out_valid && !out_ready;
    assign flushInc = flush && out_valid;

    sat_counter #(.CNT_W(CNT_W)) uStallCnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stallInc),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) uFlushCnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flushInc),
        .count (flush_cnt)
    );

endmodule
